// File: rtl/alu_datapath.sv
// alu_datapath: 8-bit arithmetic slice of the CPU datapath.
// Two operand registers (A, B) feed an add/subtract unit. Carry and zero
// flags are latched on request. The result drives the bus.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous reset, active-low
//   load_a/load_b  capture a/b into register A/B on the next rising edge
//   en_a/en_b      gate register A/B onto the ALU operand (0x00 when low)
//   a, b           operand data inputs
//   add, sub       operation select; add==sub yields 0x00 with carry 0
//   fi             latch carry/zero from the current result on the next edge
//   out            ALU result
//   carry, zero    latched flags
//
// Configuration macro ALU_REG_OUT_EN:
//   defined   -> out is a registered copy of the result (1-cycle latency)
//   undefined -> out is the combinational result (0 latency)
module alu_datapath (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_a,
  input  logic       load_b,
  input  logic       en_a,
  input  logic       en_b,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       add,
  input  logic       sub,
  input  logic       fi,
  output logic [7:0] out,
  output logic       carry,
  output logic       zero
);

  localparam int unsigned W = 8;

  logic [W-1:0] reg_a;
  logic [W-1:0] reg_b;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W:0]   sum;
  logic [W-1:0] res;
  logic         res_c;
  logic         res_z;

  // Operand register A
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_a <= '0;
    end else if (load_a) begin
      reg_a <= a;
    end
  end

  // Operand register B
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_b <= '0;
    end else if (load_b) begin
      reg_b <= b;
    end
  end

  // Output gating forces zero rather than floating the operand
  assign op_a = en_a ? reg_a : '0;
  assign op_b = en_b ? reg_b : '0;

  // Add/subtract; subtraction carry-out of 1 means no borrow
  always_comb begin
    sum = '0;
    case ({add, sub})
      2'b10:   sum = {1'b0, op_a} + {1'b0, op_b};
      2'b01:   sum = {1'b0, op_a} + {1'b0, ~op_b} + (W+1)'(1);
      default: sum = '0;
    endcase
  end

  assign res   = sum[W-1:0];
  assign res_c = sum[W];
  assign res_z = (res == '0);

  // Flag register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry <= 1'b0;
      zero  <= 1'b0;
    end else if (fi) begin
      carry <= res_c;
      zero  <= res_z;
    end
  end

`ifdef ALU_REG_OUT_EN
  // Registered result, refreshed every edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
    end else begin
      out <= res;
    end
  end
`else
  assign out = res;
`endif

endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath: scoreboard bench for alu_datapath.
// Each clock step, a reference model predicts out/carry/zero and pushes the
// prediction to a queue. The entry is popped and compared after the edge.
// Follows ALU_REG_OUT_EN when that macro is defined.
module tb_alu_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_a, load_b, en_a, en_b, add, sub, fi;
  logic [7:0] a, b;
  logic [7:0] out;
  logic       carry, zero;

  alu_datapath dut (
    .clk(clk), .rst(rst), .load_a(load_a), .load_b(load_b),
    .en_a(en_a), .en_b(en_b), .a(a), .b(b), .add(add), .sub(sub),
    .fi(fi), .out(out), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] out;
    logic       c;
    logic       z;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_a = 8'h00, m_b = 8'h00, m_outq = 8'h00;
  logic       m_c = 1'b0, m_z = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference ALU written with integer arithmetic: returns {c, r}
  function automatic logic [8:0] ref_alu(input logic [7:0] ra, input logic [7:0] rb,
                                         input logic ea, input logic eb,
                                         input logic ad, input logic sb);
    int x, y;
    x = ea ? int'(ra) : 0;
    y = eb ? int'(rb) : 0;
    if (ad && !sb) begin
      return {(x + y) > 255, 8'((x + y) % 256)};
    end else if (sb && !ad) begin
      return {x >= y, 8'((x - y + 256) % 256)};
    end
    return 9'h000;
  endfunction

  // Predict, push, clock, then pop and compare
  task automatic tick();
    logic [8:0] pre, post;
    exp_t e, got;
    if (!rst) begin
      m_a = 8'h00; m_b = 8'h00; m_c = 1'b0; m_z = 1'b0; m_outq = 8'h00;
    end
    pre = ref_alu(m_a, m_b, en_a, en_b, add, sub);
    if (rst) begin
      if (fi) begin
        m_c = pre[8];
        m_z = (pre[7:0] == 8'h00);
      end
      m_outq = pre[7:0];
      if (load_a) m_a = a;
      if (load_b) m_b = b;
    end
    post = ref_alu(m_a, m_b, en_a, en_b, add, sub);
`ifdef ALU_REG_OUT_EN
    e.out = m_outq;
`else
    e.out = post[7:0];
`endif
    e.c = m_c;
    e.z = m_z;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("sb_out", 32'(out), 32'(got.out));
    check("sb_carry", 32'(carry), 32'(got.c));
    check("sb_zero", 32'(zero), 32'(got.z));
  endtask

  task automatic set_ops(input logic la, input logic lb, input logic [7:0] va,
                         input logic [7:0] vb, input logic ad, input logic sb,
                         input logic f);
    load_a = la; load_b = lb; a = va; b = vb; add = ad; sub = sb; fi = f;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    en_a = 1'b1; en_b = 1'b1;
    set_ops(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("rst_out", 32'(out), 32'h00);
    check("rst_carry", 32'(carry), 32'h0);
    check("rst_zero", 32'(zero), 32'h0);

    // Reset held: load ignored
    set_ops(1'b1, 1'b0, 8'h55, 8'h00, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    check("rst_hold_out", 32'(out), 32'h00);
    rst = 1'b1;
    tick();
    set_ops(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    check("rst_release_load", 32'(out), 32'h55);

    // Add with carry
    set_ops(1'b1, 1'b1, 8'hF0, 8'h20, 1'b1, 1'b0, 1'b0);
    tick();
    set_ops(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    tick();
    check("add_out", 32'(out), 32'h10);
    check("add_carry", 32'(carry), 32'h1);
    check("add_zero", 32'(zero), 32'h0);

    // Subtract to zero
    set_ops(1'b1, 1'b1, 8'h33, 8'h33, 1'b0, 1'b1, 1'b0);
    tick();
    set_ops(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    tick();
    check("subz_out", 32'(out), 32'h00);
    check("subz_carry", 32'(carry), 32'h1);
    check("subz_zero", 32'(zero), 32'h1);

    // Subtract with borrow, then flags hold with fi=0
    set_ops(1'b1, 1'b1, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
    tick();
    set_ops(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    tick();
    check("subb_out", 32'(out), 32'hF0);
    check("subb_carry", 32'(carry), 32'h0);
    check("subb_zero", 32'(zero), 32'h0);
    set_ops(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    check("hold_carry", 32'(carry), 32'h0);
    check("hold_zero", 32'(zero), 32'h0);

    // Output enable gating
    set_ops(1'b1, 1'b1, 8'h07, 8'h05, 1'b1, 1'b0, 1'b0);
    en_b = 1'b0;
    tick();
    set_ops(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    check("gate_b_out", 32'(out), 32'h07);
    en_a = 1'b0;
    tick();
    tick();
    check("gate_ab_out", 32'(out), 32'h00);
    en_a = 1'b1; en_b = 1'b1;

    // Illegal op: add and sub both set
    set_ops(1'b1, 1'b1, 8'h01, 8'h01, 1'b1, 1'b1, 1'b0);
    tick();
    set_ops(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
    tick();
    check("illegal_out", 32'(out), 32'h00);
    check("illegal_carry", 32'(carry), 32'h0);
    check("illegal_zero", 32'(zero), 32'h1);

    // Load and fi on the same edge: flags see old operands (1+1=2)
    set_ops(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    set_ops(1'b1, 1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b1);
    tick();
    check("same_edge_carry", 32'(carry), 32'h0);
    check("same_edge_zero", 32'(zero), 32'h0);
    set_ops(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    tick();
    check("wrap_carry", 32'(carry), 32'h1);
    check("wrap_zero", 32'(zero), 32'h1);

    // Asynchronous reset mid-operation
    rst = 1'b0;
    #1;
    check("async_out", 32'(out), 32'h00);
    check("async_carry", 32'(carry), 32'h0);
    check("async_zero", 32'(zero), 32'h0);
    set_ops(1'b1, 1'b1, 8'hAA, 8'h11, 1'b1, 1'b0, 1'b1);
    tick();
    rst = 1'b1;
    tick();

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      set_ops(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      en_a = ($urandom_range(0, 3) != 0);
      en_b = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
